// File: rtl/demux_pkg.sv
// Shared constants, lane type and the round-robin grant helper for the
// demux lane deserializer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    // Returns the first requesting lane after ptr, wrapping around; ptr itself
    // has the lowest priority. With no request the result is ptr and the
    // caller must qualify it with |req.
    function automatic lane_t next_rr(input lane_t ptr, input logic [NUM_LANES-1:0] req);
        lane_t grant;
        lane_t idx;
        grant = ptr;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int i = NUM_LANES; i >= 1; i--) begin
            idx = ptr + lane_t'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-request round-robin arbiter with a registered last-grant pointer.
// The pointer resets to lane 3 so that lane 0 has first priority.
module rr_arb4
    import demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] req,
    input  logic                 advance,
    output logic                 gnt_valid,
    output lane_t                gnt_lane
);

    lane_t ptr;

    assign gnt_valid = |req;
    assign gnt_lane  = next_rr(ptr, req);

    // Remember the last granted lane whenever a grant is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= lane_t'(NUM_LANES - 1);
        end else if (advance && gnt_valid) begin
            ptr <= gnt_lane;
        end
    end

endmodule

// File: rtl/demux_lane_deserializer.sv
// Four-lane serial-to-parallel deserializer fed by a 1x4 demux.
// Each bit_valid strobe shifts y[sel] LSB-first into lane sel; a full word
// is parked in that lane's holding register and a round-robin arbiter moves
// parked words into a single output slot.
// Optional build macro DESER_PARITY_EN: frames carry a trailing even-parity
// bit and the out_perr port reports a mismatch alongside each word.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_valid,
// out_lane, out_data (and out_perr) hold steady. The slot reloads whenever it
// is empty or being emptied on that edge, so transfers can be back-to-back.
module demux_lane_deserializer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic [1:0]           sel,
    input  logic [3:0]           y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_lane,
    output logic [WIDTH-1:0]     out_data,
    output logic [3:0]           overflow,
`ifdef DESER_PARITY_EN
    output logic                 out_perr,
`endif
    input  logic                 ovf_clr
);

`ifdef DESER_PARITY_EN
    localparam int FRAME_W = WIDTH + 1;
`else
    localparam int FRAME_W = WIDTH;
`endif
    localparam int              CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    logic                                bit_in;
    logic                                load;
    logic                                gnt_valid;
    lane_t                               gnt_lane;
    logic [NUM_LANES-1:0]                pend;
    logic [NUM_LANES-1:0]                move;
    logic [NUM_LANES-1:0][WIDTH-1:0]     hold;
`ifdef DESER_PARITY_EN
    logic [NUM_LANES-1:0]                hold_perr;
`endif

    assign bit_in = y[sel];
    assign load   = !out_valid || out_ready;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [WIDTH-1:0] shreg;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] word_in;
        logic [WIDTH-1:0] hold_r;
        logic             pend_r;
        logic             ovf_r;
        logic             hit;
        logic             last;
        logic             complete;
`ifdef DESER_PARITY_EN
        logic             perr_in;
        logic             perr_r;
`endif

        assign hit      = bit_valid && (sel == lane_t'(l));
        assign last     = (cnt == LAST);
        assign complete = hit && last;
        assign move[l]  = load && gnt_valid && (gnt_lane == lane_t'(l));
        // The mask is zero at the parity position, leaving the word intact.
        assign mask     = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;
        assign word_in  = (shreg & ~mask) | ({WIDTH{bit_in}} & mask);
`ifdef DESER_PARITY_EN
        assign perr_in  = (^shreg) ^ bit_in;
`endif

        // Shift register and bit counter; the counter wraps on the last bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (hit) begin
                shreg <= word_in;
                cnt   <= last ? '0 : cnt + 1'b1;
            end
        end

        // Holding register, pending flag and sticky overflow flag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_r <= '0;
                pend_r <= 1'b0;
                ovf_r  <= 1'b0;
`ifdef DESER_PARITY_EN
                perr_r <= 1'b0;
`endif
            end else begin
                if (complete && (!pend_r || move[l])) begin
                    hold_r <= word_in;
                    pend_r <= 1'b1;
`ifdef DESER_PARITY_EN
                    perr_r <= perr_in;
`endif
                end else if (move[l]) begin
                    pend_r <= 1'b0;
                end
                // A new overflow event takes precedence over a clear.
                if (complete && pend_r && !move[l]) begin
                    ovf_r <= 1'b1;
                end else if (ovf_clr) begin
                    ovf_r <= 1'b0;
                end
            end
        end

        assign hold[l]     = hold_r;
        assign pend[l]     = pend_r;
        assign overflow[l] = ovf_r;
`ifdef DESER_PARITY_EN
        assign hold_perr[l] = perr_r;
`endif
    end

    rr_arb4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .advance   (load),
        .gnt_valid (gnt_valid),
        .gnt_lane  (gnt_lane)
    );

    // Output slot: reload from the granted lane whenever the slot frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_data  <= '0;
`ifdef DESER_PARITY_EN
            out_perr  <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_lane <= gnt_lane;
                out_data <= hold[gnt_lane];
`ifdef DESER_PARITY_EN
                out_perr <= hold_perr[gnt_lane];
`endif
            end
        end
    end

endmodule
